// File: rtl/ram_burst_rd.sv
// Command-driven port-B read sequencer for the simple dual-port block RAM.
// Issues a wrapping address burst, tracks RAM latency and emits a valid/last stream.
module ram_burst_rd #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              rd_loop,
    input  logic              rd_abort,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              ram_en_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              loop_q;
    // Stage i holds the {valid, last} tag of the issue made i cycles ago.
    logic [RD_LAT:0]   pipe_vld_q;
    logic [RD_LAT:0]   pipe_last_q;

    logic [LEN_W-1:0]  len_clamp;
    logic [LEN_W-1:0]  cnt_inc;
    logic              cur_last;
    logic              drained;

    always_comb begin
        len_clamp = (rd_len > MaxLen) ? MaxLen : rd_len;
        cnt_inc   = cnt_q + 1'b1;
        cur_last  = (cnt_q == len_q - 1'b1);
        // Final word is at the RAM output with nothing queued behind it.
        drained   = pipe_vld_q[RD_LAT] && (pipe_vld_q[RD_LAT-1:0] == '0);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            loop_q      <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            rd_busy     <= 1'b0;
            rd_done     <= 1'b0;
            ram_en_b    <= 1'b0;
            ram_addr_b  <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
        end else begin
            pipe_vld_q[RD_LAT:1]  <= pipe_vld_q[RD_LAT-1:0];
            pipe_last_q[RD_LAT:1] <= pipe_last_q[RD_LAT-1:0];
            pipe_vld_q[0]         <= 1'b0;
            pipe_last_q[0]        <= 1'b0;
            ram_en_b              <= 1'b0;
            ram_addr_b            <= '0;
            rd_done               <= 1'b0;

            dout_valid <= pipe_vld_q[RD_LAT];
            dout_last  <= pipe_vld_q[RD_LAT] & pipe_last_q[RD_LAT];
            if (pipe_vld_q[RD_LAT]) begin
                dout <= ram_rd_data;
            end

            unique case (state_q)
                StIdle: begin
                    if (rd_start && (rd_len != '0)) begin
                        base_q         <= rd_base;
                        len_q          <= len_clamp;
                        loop_q         <= rd_loop;
                        cnt_q          <= '0;
                        ram_en_b       <= 1'b1;
                        ram_addr_b     <= rd_base;
                        pipe_vld_q[0]  <= 1'b1;
                        pipe_last_q[0] <= (len_clamp == LEN_W'(1));
                        rd_busy        <= 1'b1;
                        state_q        <= StRead;
                    end
                end
                StRead: begin
                    if (rd_abort || (cur_last && !loop_q)) begin
                        state_q <= StDrain;
                    end else if (cur_last) begin
                        cnt_q          <= '0;
                        ram_en_b       <= 1'b1;
                        ram_addr_b     <= base_q;
                        pipe_vld_q[0]  <= 1'b1;
                        pipe_last_q[0] <= (len_q == LEN_W'(1));
                    end else begin
                        cnt_q          <= cnt_inc;
                        ram_en_b       <= 1'b1;
                        ram_addr_b     <= base_q + ADDR_W'(cnt_inc);
                        pipe_vld_q[0]  <= 1'b1;
                        pipe_last_q[0] <= (cnt_inc == len_q - 1'b1);
                    end
                end
                StDrain: begin
                    // Hold off IDLE for the rd_done cycle so busy covers it.
                    if (rd_done) begin
                        rd_busy <= 1'b0;
                        state_q <= StIdle;
                    end else if (drained) begin
                        rd_done <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/ram_burst_rd.md
# ram_burst_rd

Parametrised port-B read sequencer for the simple dual-port block RAM. It replaces the fixed 64-word, flag-driven reader with a command-driven engine. On each command it reads a programmable burst (base address, length) with address wrap, and compensates a configurable RAM read latency. Data is delivered as a valid/last stream, with single-shot or continuous-loop modes and abort. It sits between the RAM's port B and the downstream consumer (checker, UART/display path).

## Interface
- `ADDR_W`, default 6: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, default 8: RAM data width.
- `RD_LAT`, default 1: RAM read latency in cycles; legal range 1..3.
- `LEN_W`, default ADDR_W+1: width of the burst-length field.

Ports:
- `sys_clk` in 1: single clock; all logic on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `rd_start` in 1: command strobe, sampled only in IDLE.
- `rd_base` in ADDR_W: first address of the burst.
- `rd_len` in LEN_W: words per pass.
  - 0 means the command is ignored.
  - Values above 2^ADDR_W are clamped to 2^ADDR_W.
- `rd_loop` in 1: 1 selects continuous mode, which repeats passes until aborted.
- `rd_abort` in 1: stop issuing reads; in-flight data is still delivered.
- `rd_busy` out 1: high from the first issue cycle through the rd_done cycle.
- `rd_done` out 1: one-cycle pulse when the burst, or the aborted burst, has fully drained.
- `ram_en_b` out 1: RAM port-B enable.
- `ram_addr_b` out ADDR_W: RAM port-B address.
- `ram_rd_data` in DATA_W: RAM port-B read data.
- `dout` out DATA_W: registered read data; holds its value while dout_valid is low.
- `dout_valid` out 1: dout carries a word this cycle.
- `dout_last` out 1: qualifies the final word of each pass; only valid when dout_valid is high.

## Operation
- FSM has three states: IDLE, READ, DRAIN. All outputs are registered.
- IDLE:
  - On `rd_start` with `rd_len` != 0: latch base, the clamped length and loop into internal registers, clear the word counter `cnt`, and go to READ.
  - `rd_start` with `rd_len` == 0: no effect, no rd_done.
  - `rd_start` outside IDLE is ignored. Command inputs are don't-care after the latch cycle.
- READ:
  - Every cycle: `ram_en_b`=1 and `ram_addr_b` = (base + cnt) mod 2^ADDR_W. The address wraps from 2^ADDR_W-1 to 0.
  - The issue with cnt == len-1 is tagged "last".
  - After the last issue: if loop=1 and no abort, cnt goes to 0 and the next cycle reissues base. Otherwise go to DRAIN.
  - Abort sampled during READ: the read issued in that cycle is the final one, and the next state is DRAIN.
  - Abort in the same cycle as a last-tagged issue: the tag is kept, and the pass completes normally.
- DRAIN:
  - `ram_en_b`=0 and `ram_addr_b`=0.
  - Wait until the final in-flight word is output, then pulse `rd_done` together with that word, drop `rd_busy`, and return to IDLE.
- Read pipeline:
  - An RD_LAT+1-stage shift register carries {valid, last} alongside each issue.
  - `dout` is captured from `ram_rd_data` when the stage-RD_LAT valid bit is high.
- Aborted bursts:
  - No `dout_last` unless the last-tagged word was already issued.
  - `rd_done` still pulses.
- In loop mode, `rd_done` occurs only after an abort.
- Counter arithmetic is LEN_W bits. Address arithmetic is ADDR_W bits and truncates (wraps).
- Reset, asserted at any time including mid-burst:
  - Immediately forces IDLE and clears the pipeline, discarding in-flight data.
  - Drives every output to 0: ram_en_b, ram_addr_b, dout, dout_valid, dout_last, rd_busy, rd_done.

## Timing
- Cycle T is the cycle in which `rd_start` is sampled in IDLE.
- The first issue is at T+1: `ram_en_b`=1, `ram_addr_b`=base, `rd_busy`=1.
- The RAM returns data for an issue at cycle k during cycle k+RD_LAT. `dout_valid` for that word is at k+RD_LAT+1.
- Single-shot burst of N words:
  - Issues occupy T+1..T+N.
  - `dout_valid` is high for T+RD_LAT+2..T+N+RD_LAT+1.
  - `dout_last`, `rd_done` and the final `rd_busy` cycle all fall at T+N+RD_LAT+1.
  - `rd_busy` is 0 from T+N+RD_LAT+2.
  - A new `rd_start` is accepted from T+N+RD_LAT+2.
- Abort sampled at cycle A in READ:
  - `ram_en_b`=0 from A+1.
  - Final `dout_valid` and `rd_done` at A+RD_LAT+1.
- Loop mode: issues are gap-free across pass boundaries, so `dout_valid` stays continuously high.

## Test plan
- Single-shot, RD_LAT=1, base=0, len=64, RAM preloaded with addr:
  - 64 consecutive dout 0..63 at T+3..T+66.
  - dout_last and rd_done at T+66; busy low at T+67.
- Wrap, ADDR_W=6, base=60, len=8:
  - ram_addr_b sequence 60,61,62,63,0,1,2,3; dout_last on the 8th word.
- Loop with abort, RD_LAT=2, base=10, len=4, loop=1:
  - Addresses repeat 10..13 with dout_last every 4th word.
  - Abort at the 2nd issue of pass 3: en drops next cycle, 2 more words out with no last, rd_done with the final word.
- Latency sweep RD_LAT=1,2,3, len=1:
  - A single dout_valid+last+rd_done at T+RD_LAT+2.
- Edge commands:
  - rd_len=0: no activity.
  - rd_len=100 with ADDR_W=6: exactly 64 words.
  - rd_start while busy: ignored.
  - Abort coincident with the last issue: normal completion with last.
- Reset mid-burst at word 20:
  - All outputs 0 in the same cycle.
  - After release, a fresh burst behaves as in the first scenario.
